// File: rtl/microseq_pkg.sv
// -----------------------------------------------------------------------------
// microseq_pkg
// Shared definitions for the microprogrammed controller: opcode encodings and
// helper functions that locate each microword field from the block
// parameters (N_COND, N_OUT, ADDR_W).
// Microword layout, MSB -> LSB: op[3] | csel[CSEL_W] | pol[1] | addr[ADDR_W] | out[N_OUT]
// -----------------------------------------------------------------------------
package microseq_pkg;

   localparam int OP_W = 3;

   localparam logic [2:0] OP_CONT = 3'd0;
   localparam logic [2:0] OP_JMP  = 3'd1;
   localparam logic [2:0] OP_BR   = 3'd2;
   localparam logic [2:0] OP_WAIT = 3'd3;
   localparam logic [2:0] OP_CALL = 3'd4;
   localparam logic [2:0] OP_RET  = 3'd5;
   localparam logic [2:0] OP_LDC  = 3'd6;
   localparam logic [2:0] OP_DJNZ = 3'd7;

   // One extra select bit so there is always an out-of-range code meaning "true".
   function automatic int csel_w(input int n_cond);
      return $clog2(n_cond) + 1;
   endfunction

   function automatic int word_w(input int n_cond, input int n_out, input int addr_w);
      return OP_W + csel_w(n_cond) + 1 + addr_w + n_out;
   endfunction

   function automatic int addr_lsb(input int n_out);
      return n_out;
   endfunction

   function automatic int pol_lsb(input int n_out, input int addr_w);
      return n_out + addr_w;
   endfunction

   function automatic int csel_lsb(input int n_out, input int addr_w);
      return n_out + addr_w + 1;
   endfunction

   function automatic int op_lsb(input int n_cond, input int n_out, input int addr_w);
      return n_out + addr_w + 1 + csel_w(n_cond);
   endfunction

endpackage

// File: rtl/microseq_stack.sv
// -----------------------------------------------------------------------------
// microseq_stack
// Small LIFO holding subroutine return addresses.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr_i          synchronous clear (controller idle)
//   push_i/pop_i   push data_i / pop top (ignored when full / empty)
//   data_i         value to push
//   top_o          most recently pushed entry
//   full_o/empty_o occupancy flags
// -----------------------------------------------------------------------------
module microseq_stack
   import microseq_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] top_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  entry_q [2**IW];
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic [IW-1:0] wr_idx_s;
   logic [IW-1:0] rd_idx_s;

   assign full_o   = (count_q == CW'(DEPTH));
   assign empty_o  = (count_q == {CW{1'b0}});
   assign wr_idx_s = IW'(count_q);
   assign rd_idx_s = IW'(count_q - CW'(1));
   assign top_o    = entry_q[rd_idx_s];

   // Occupancy update: clear wins, then push, then pop.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = {CW{1'b0}};
      end else if (push_i && !full_o) begin
         count_d = count_q + CW'(1);
      end else if (pop_i && !empty_o) begin
         count_d = count_q - CW'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= {CW{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   // Entry storage; contents are meaningless above count_q so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_i && !full_o && !clr_i) begin
         entry_q[wr_idx_s] <= data_i;
      end
   end

endmodule

// File: rtl/microseq_ctrl.sv
// -----------------------------------------------------------------------------
// microseq_ctrl
// Microprogrammed controller executing a writable microprogram with
// conditional branch, wait, call/return and counted loops.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   run        1 = execute, 0 = idle and allow programming
//   condicion  condition inputs (optionally two-flop synchronised)
//   prog_we    microword write strobe, honoured only while run = 0
//   prog_addr  write address
//   prog_data  microword to write
//   salida     registered control outputs
//   pc         current microaddress
//   waiting    executing WAIT whose condition is unmet (combinational)
//   err        sticky stack fault, execution frozen until run drops
// -----------------------------------------------------------------------------
module microseq_ctrl
   import microseq_pkg::*;
#(
   parameter int N_COND      = 6,
   parameter int N_OUT       = 8,
   parameter int ADDR_W      = 5,
   parameter int STACK_DEPTH = 2,
   parameter bit SYNC_COND   = 1'b1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     run,
   input  logic [N_COND-1:0]                        condicion,
   input  logic                                     prog_we,
   input  logic [ADDR_W-1:0]                        prog_addr,
   input  logic [word_w(N_COND, N_OUT, ADDR_W)-1:0] prog_data,
   output logic [N_OUT-1:0]                         salida,
   output logic [ADDR_W-1:0]                        pc,
   output logic                                     waiting,
   output logic                                     err
);

   localparam int CSEL_W  = csel_w(N_COND);
   localparam int WORD_W  = word_w(N_COND, N_OUT, ADDR_W);
   localparam int DEPTH   = 1 << ADDR_W;
   localparam int A_LSB   = addr_lsb(N_OUT);
   localparam int P_LSB   = pol_lsb(N_OUT, ADDR_W);
   localparam int C_LSB   = csel_lsb(N_OUT, ADDR_W);
   localparam int O_LSB   = op_lsb(N_COND, N_OUT, ADDR_W);

   logic [WORD_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [N_OUT-1:0]  salida_q, salida_d;
   logic              err_q, err_d;

   logic [N_COND-1:0] cond_s;
   logic [WORD_W-1:0] word_s;
   logic [2:0]        op_s;
   logic [CSEL_W-1:0] csel_s;
   logic              pol_s;
   logic [ADDR_W-1:0] addr_s;
   logic [N_OUT-1:0]  out_s;
   logic              c_s;
   logic              t_s;
   logic [ADDR_W-1:0] pc_inc_s;

   logic              push_s, pop_s;
   logic [ADDR_W-1:0] top_s;
   logic              full_s, empty_s;

   // Condition input conditioning.
   generate
      if (SYNC_COND) begin : g_sync
         logic [N_COND-1:0] sync1_q;
         logic [N_COND-1:0] sync2_q;

         // Two-flop synchroniser for asynchronous condition sources.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               sync1_q <= {N_COND{1'b0}};
               sync2_q <= {N_COND{1'b0}};
            end else begin
               sync1_q <= condicion;
               sync2_q <= sync1_q;
            end
         end
         assign cond_s = sync2_q;
      end else begin : g_direct
         assign cond_s = condicion;
      end
   endgenerate

   // Microprogram store: written only while idle, not reset.
   always_ff @(posedge clk) begin
      if (prog_we && !run) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

   assign word_s   = mem_q[pc_q];
   assign op_s     = word_s[O_LSB +: 3];
   assign csel_s   = word_s[C_LSB +: CSEL_W];
   assign pol_s    = word_s[P_LSB];
   assign addr_s   = word_s[A_LSB +: ADDR_W];
   assign out_s    = word_s[0 +: N_OUT];
   assign pc_inc_s = pc_q + ADDR_W'(1);

   // Condition select; codes at or above N_COND read as constant true.
   always_comb begin
      c_s = 1'b1;
      for (int i = 0; i < N_COND; i++) begin
         c_s = (csel_s == CSEL_W'(i)) ? cond_s[i] : c_s;
      end
   end

   assign t_s = (c_s == pol_s);

   // Next-state logic: idle clear, fault freeze, or execute the current word.
   always_comb begin
      pc_d     = pc_q;
      cnt_d    = cnt_q;
      salida_d = salida_q;
      err_d    = err_q;
      push_s   = 1'b0;
      pop_s    = 1'b0;
      if (!run) begin
         pc_d     = {ADDR_W{1'b0}};
         cnt_d    = {ADDR_W{1'b0}};
         salida_d = {N_OUT{1'b0}};
         err_d    = 1'b0;
      end else if (err_q) begin
         pc_d = pc_q;
      end else begin
         salida_d = out_s;
         case (op_s)
            OP_CONT: pc_d = pc_inc_s;
            OP_JMP:  pc_d = addr_s;
            OP_BR:   pc_d = t_s ? addr_s : pc_inc_s;
            OP_WAIT: pc_d = t_s ? pc_inc_s : pc_q;
            OP_CALL: begin
               // A faulting edge leaves every architectural register untouched.
               if (full_s) begin
                  err_d    = 1'b1;
                  salida_d = salida_q;
               end else begin
                  push_s = 1'b1;
                  pc_d   = addr_s;
               end
            end
            OP_RET: begin
               if (empty_s) begin
                  err_d    = 1'b1;
                  salida_d = salida_q;
               end else begin
                  pop_s = 1'b1;
                  pc_d  = top_s;
               end
            end
            OP_LDC: begin
               cnt_d = addr_s;
               pc_d  = pc_inc_s;
            end
            OP_DJNZ: begin
               if (cnt_q != {ADDR_W{1'b0}}) begin
                  cnt_d = cnt_q - ADDR_W'(1);
                  pc_d  = addr_s;
               end else begin
                  pc_d = pc_inc_s;
               end
            end
            default: pc_d = pc_inc_s;
         endcase
      end
   end

   // Architectural state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= {ADDR_W{1'b0}};
         cnt_q    <= {ADDR_W{1'b0}};
         salida_q <= {N_OUT{1'b0}};
         err_q    <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         cnt_q    <= cnt_d;
         salida_q <= salida_d;
         err_q    <= err_d;
      end
   end

   microseq_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (ADDR_W)
   ) u_stack (
      .clk     (clk),
      .rst_n   (rst),
      .clr_i   (~run),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .data_i  (pc_inc_s),
      .top_o   (top_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   assign salida  = salida_q;
   assign pc      = pc_q;
   assign err     = err_q;
   // Gated so it reads 0 in reset and while idle.
   assign waiting = rst & run & ~err_q & (op_s == OP_WAIT) & ~t_s;

endmodule

// File: tb/tb_microseq_ctrl.sv
// Bench for microseq_ctrl (default parameters, synchronised conditions).
module tb_microseq_ctrl;
   import microseq_pkg::*;

   localparam int N_COND = 6;
   localparam int N_OUT  = 8;
   localparam int ADDR_W = 5;
   localparam int WORD_W = 21;

   logic              clk = 1'b0;
   logic              rst;
   logic              run;
   logic [N_COND-1:0] condicion;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [WORD_W-1:0] prog_data;
   logic [N_OUT-1:0]  salida;
   logic [ADDR_W-1:0] pc;
   logic              waiting;
   logic              err;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [ADDR_W-1:0] pc;
      logic [N_OUT-1:0]  sal;
      logic              er;
   } exp_t;

   typedef struct {
      logic [N_COND-1:0] cond;
      logic [N_OUT-1:0]  sal;
      logic [ADDR_W-1:0] pc;
      logic              wt;
   } vec_t;

   exp_t sb_q[$];
   vec_t lv[6];

   microseq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .condicion (condicion),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .salida    (salida),
      .pc        (pc),
      .waiting   (waiting),
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [WORD_W-1:0] mk(input logic [2:0] op, input logic [3:0] csel,
                                             input logic pol, input logic [4:0] a,
                                             input logic [7:0] o);
      return {op, csel, pol, a, o};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input logic [4:0] a, input logic [WORD_W-1:0] w);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = w;
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic expect_cyc(input logic [4:0] p, input logic [7:0] s, input logic e);
      exp_t x;
      x.pc  = p;
      x.sal = s;
      x.er  = e;
      sb_q.push_back(x);
   endtask

   // Advances one edge per queued expectation and compares.
   task automatic drain(input string nm);
      exp_t x;
      while (sb_q.size() > 0) begin
         tick();
         x = sb_q.pop_front();
         chk({nm, "_pc"},  32'(pc),     32'(x.pc));
         chk({nm, "_sal"}, 32'(salida), 32'(x.sal));
         chk({nm, "_err"}, 32'(err),    32'(x.er));
      end
   endtask

   initial begin
      int aa_cnt;
      vec_t v;

      // Legacy demo vectors: condition applied, resulting output, pc, waiting.
      lv[0] = '{6'b000001, 8'h11, 5'd2,  1'b1};
      lv[1] = '{6'b000010, 8'h22, 5'd4,  1'b1};
      lv[2] = '{6'b000100, 8'h33, 5'd6,  1'b1};
      lv[3] = '{6'b001000, 8'h44, 5'd8,  1'b1};
      lv[4] = '{6'b010000, 8'h55, 5'd10, 1'b1};
      lv[5] = '{6'b100000, 8'h66, 5'd12, 1'b0};

      rst = 1'b0; run = 1'b0; condicion = '0;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("reset_pc",   32'(pc),      32'd0);
      chk("reset_sal",  32'(salida),  32'h0);
      chk("reset_err",  32'(err),     32'd0);
      chk("reset_wait", 32'(waiting), 32'd0);

      for (int i = 0; i < 32; i++) prog(5'(i), '0);

      // ---- legacy demo ----
      for (int k = 0; k < 6; k++) begin
         prog(5'(2 * k), mk(OP_WAIT, 4'(k), 1'b1, 5'd0, (k == 0) ? 8'h00 : 8'(8'h11 * k)));
         prog(5'(2 * k + 1), mk(OP_CONT, 4'd15, 1'b0, 5'd0, 8'(8'h11 * (k + 1))));
      end
      prog(5'd12, mk(OP_JMP, 4'd0, 1'b0, 5'd12, 8'h66));
      run = 1'b1;
      tick();
      chk("legacy_idle_wait", 32'(waiting), 32'd1);
      chk("legacy_idle_pc",   32'(pc),      32'd0);
      chk("legacy_idle_sal",  32'(salida),  32'h0);
      for (int i = 0; i < 6; i++) begin
         sb_q.push_back('{pc: lv[i].pc, sal: lv[i].sal, er: lv[i].wt});
         condicion = lv[i].cond;
         for (int n = 0; n < 8; n++) begin
            tick();
            if (salida == lv[i].sal) break;
         end
         v.cond = lv[i].cond;
         begin
            exp_t x;
            x = sb_q.pop_front();
            chk("legacy_sal",  32'(salida),  32'(x.sal));
            chk("legacy_pc",   32'(pc),      32'(x.pc));
            chk("legacy_wait", 32'(waiting), 32'(x.er));
         end
         if (lv[i].wt) begin
            tick();
            chk("legacy_hold_sal",  32'(salida),  32'(lv[i].sal));
            chk("legacy_hold_wait", 32'(waiting), 32'd1);
         end
      end

      // ---- asynchronous reset mid-run ----
      rst = 1'b0;
      #1;
      chk("async_rst_sal", 32'(salida), 32'h0);
      chk("async_rst_pc",  32'(pc),     32'd0);
      chk("async_rst_err", 32'(err),    32'd0);
      run = 1'b0; condicion = '0;
      tick();
      rst = 1'b1;

      // ---- counted loop ----
      prog(5'd0, mk(OP_LDC,  4'd15, 1'b0, 5'd3, 8'h00));
      prog(5'd1, mk(OP_CONT, 4'd15, 1'b0, 5'd0, 8'hAA));
      prog(5'd2, mk(OP_DJNZ, 4'd15, 1'b0, 5'd1, 8'h00));
      prog(5'd3, mk(OP_CONT, 4'd15, 1'b0, 5'd0, 8'h00));
      prog(5'd4, mk(OP_JMP,  4'd15, 1'b0, 5'd4, 8'h00));
      run = 1'b1;
      expect_cyc(5'd1, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         expect_cyc(5'd2, 8'hAA, 1'b0);
         expect_cyc(5'd1, 8'h00, 1'b0);
      end
      sb_q[8].pc = 5'd3;
      expect_cyc(5'd4, 8'h00, 1'b0);
      expect_cyc(5'd4, 8'h00, 1'b0);
      aa_cnt = 0;
      while (sb_q.size() > 0) begin
         exp_t x;
         tick();
         if (salida == 8'hAA) aa_cnt++;
         x = sb_q.pop_front();
         chk("loop_pc",  32'(pc),     32'(x.pc));
         chk("loop_sal", 32'(salida), 32'(x.sal));
      end
      chk("loop_aa_edges", 32'(aa_cnt), 32'd4);
      run = 1'b0;
      tick();

      // ---- branch and condition select ----
      prog(5'd0,  mk(OP_BR,  4'd15, 1'b1, 5'd5,  8'h42));
      prog(5'd5,  mk(OP_BR,  4'd0,  1'b0, 5'd9,  8'h43));
      prog(5'd9,  mk(OP_BR,  4'd1,  1'b1, 5'd0,  8'h44));
      prog(5'd10, mk(OP_JMP, 4'd0,  1'b0, 5'd10, 8'h45));
      run = 1'b1;
      expect_cyc(5'd5,  8'h42, 1'b0);
      expect_cyc(5'd9,  8'h43, 1'b0);
      expect_cyc(5'd10, 8'h44, 1'b0);
      expect_cyc(5'd10, 8'h45, 1'b0);
      drain("branch");
      run = 1'b0;
      tick();

      // ---- nested call/return ----
      prog(5'd0,  mk(OP_CALL, 4'd15, 1'b0, 5'd8,  8'h01));
      prog(5'd1,  mk(OP_CONT, 4'd15, 1'b0, 5'd0,  8'h02));
      prog(5'd2,  mk(OP_JMP,  4'd15, 1'b0, 5'd2,  8'h03));
      prog(5'd8,  mk(OP_CALL, 4'd15, 1'b0, 5'd16, 8'h10));
      prog(5'd9,  mk(OP_RET,  4'd15, 1'b0, 5'd0,  8'h11));
      prog(5'd16, mk(OP_RET,  4'd15, 1'b0, 5'd0,  8'h20));
      run = 1'b1;
      expect_cyc(5'd8,  8'h01, 1'b0);
      expect_cyc(5'd16, 8'h10, 1'b0);
      expect_cyc(5'd9,  8'h20, 1'b0);
      expect_cyc(5'd1,  8'h11, 1'b0);
      expect_cyc(5'd2,  8'h02, 1'b0);
      expect_cyc(5'd2,  8'h03, 1'b0);
      drain("nest");
      run = 1'b0;
      tick();

      // ---- stack overflow on third CALL ----
      prog(5'd16, mk(OP_CALL, 4'd15, 1'b0, 5'd24, 8'h30));
      run = 1'b1;
      expect_cyc(5'd8,  8'h01, 1'b0);
      expect_cyc(5'd16, 8'h10, 1'b0);
      expect_cyc(5'd16, 8'h10, 1'b1);
      expect_cyc(5'd16, 8'h10, 1'b1);
      drain("overflow");
      run = 1'b0;
      tick();
      chk("overflow_clear_err", 32'(err), 32'd0);
      chk("overflow_clear_pc",  32'(pc),  32'd0);

      // ---- RET on empty stack ----
      prog(5'd0, mk(OP_RET, 4'd15, 1'b0, 5'd0, 8'h77));
      run = 1'b1;
      expect_cyc(5'd0, 8'h00, 1'b1);
      expect_cyc(5'd0, 8'h00, 1'b1);
      drain("underflow");
      run = 1'b0;
      tick();
      chk("underflow_clear_err", 32'(err), 32'd0);

      // ---- wrap at top address and programming guard ----
      prog(5'd31, mk(OP_CONT, 4'd15, 1'b0, 5'd0,  8'h5A));
      prog(5'd0,  mk(OP_JMP,  4'd15, 1'b0, 5'd31, 8'h00));
      run = 1'b1;
      prog_we = 1'b1; prog_addr = 5'd31; prog_data = mk(OP_CONT, 4'd15, 1'b0, 5'd0, 8'hFF);
      tick();
      prog_we = 1'b0;
      chk("wrap_pc_31", 32'(pc), 32'd31);
      expect_cyc(5'd0,  8'h5A, 1'b0);
      expect_cyc(5'd31, 8'h00, 1'b0);
      expect_cyc(5'd0,  8'h5A, 1'b0);
      drain("wrap_guard");
      run = 1'b0;
      tick();
      chk("drop_run_pc",  32'(pc),     32'd0);
      chk("drop_run_sal", 32'(salida), 32'h0);
      prog(5'd31, mk(OP_CONT, 4'd15, 1'b0, 5'd0, 8'hFF));
      run = 1'b1;
      expect_cyc(5'd31, 8'h00, 1'b0);
      expect_cyc(5'd0,  8'hFF, 1'b0);
      drain("prog_visible");
      run = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
